// File: rtl/instr_loader_if.sv
// Byte-stream receive bus plus instruction-memory write bus for the boot loader.
// The master modport is the loader; slave is the UART/memory side.
interface instr_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] instr_in;
   logic [31:0] instr_in_addr;
   logic        instr_we;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, instr_in, instr_in_addr, instr_we
   );
   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, instr_in, instr_in_addr, instr_we
   );
endinterface

// File: rtl/instr_loader.sv
// Boot-time loader: 16-bit LE word count followed by LE 32-bit instructions,
// written to instruction memory while the core is held in reset.
module instr_loader #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int          MAX_WORDS   = 256,
   parameter int          TIMEOUT_CYC = 1000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   instr_loader_if.master     bus,
   output logic               core_hold,
   output logic               load_done,
   output logic               load_err,
   output logic [15:0]        words_loaded
);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_e;

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
   localparam logic [31:0] TMAX  = 32'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [23:0] word_q, word_d;
   logic [31:0] timer_q, timer_d;
   logic        rx_ready_q, rx_ready_d;
   logic        instr_we_q, instr_we_d;
   logic [31:0] instr_in_q, instr_in_d;
   logic [31:0] addr_q, addr_d;
   logic        core_hold_q, core_hold_d;
   logic        load_done_q, load_done_d;
   logic        load_err_q, load_err_d;
   logic [15:0] words_loaded_q, words_loaded_d;

   logic        accept, timed_out, len_bad, last_word, final_byte;
   logic [15:0] len_full;

   assign accept     = bus.rx_valid & rx_ready_q;
   assign timed_out  = (timer_q == TMAX);
   assign len_full   = {bus.rx_data, len_q[7:0]};
   assign len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > MAX_W);
   assign last_word  = (word_idx_q == len_q - 16'd1);
   assign final_byte = (state_q == DATA) && accept && (byte_idx_q == 2'd3) && last_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         len_q          <= '0;
         byte_idx_q     <= '0;
         word_idx_q     <= '0;
         word_q         <= '0;
         timer_q        <= '0;
         rx_ready_q     <= 1'b0;
         instr_we_q     <= 1'b0;
         instr_in_q     <= '0;
         addr_q         <= '0;
         core_hold_q    <= 1'b1;
         load_done_q    <= 1'b0;
         load_err_q     <= 1'b0;
         words_loaded_q <= '0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         byte_idx_q     <= byte_idx_d;
         word_idx_q     <= word_idx_d;
         word_q         <= word_d;
         timer_q        <= timer_d;
         rx_ready_q     <= rx_ready_d;
         instr_we_q     <= instr_we_d;
         instr_in_q     <= instr_in_d;
         addr_q         <= addr_d;
         core_hold_q    <= core_hold_d;
         load_done_q    <= load_done_d;
         load_err_q     <= load_err_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) state_d = LEN_LO;
         LEN_LO: begin
            if (accept)         state_d = LEN_HI;
            else if (timed_out) state_d = ERROR;
         end
         LEN_HI: begin
            if (accept)         state_d = len_bad ? ERROR : DATA;
            else if (timed_out) state_d = ERROR;
         end
         DATA: begin
            // Leave only after the final word's strobe cycle has been issued.
            if (instr_we_q && (words_loaded_q == len_q)) state_d = DONE;
            else if (!accept && timed_out)                state_d = ERROR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      len_d          = len_q;
      byte_idx_d     = byte_idx_q;
      word_idx_d     = word_idx_q;
      word_d         = word_q;
      timer_d        = timer_q;
      instr_we_d     = 1'b0;
      instr_in_d     = instr_in_q;
      addr_d         = addr_q;
      words_loaded_d = words_loaded_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               len_d          = '0;
               byte_idx_d     = '0;
               word_idx_d     = '0;
               timer_d        = '0;
               words_loaded_d = '0;
            end
         end
         LEN_LO, LEN_HI, DATA: begin
            timer_d = accept ? 32'd0 : timer_q + 32'd1;
            if (accept && state_q == LEN_LO) len_d[7:0]  = bus.rx_data;
            if (accept && state_q == LEN_HI) len_d[15:8] = bus.rx_data;
            if (accept && state_q == DATA) begin
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_d[7:0]   = bus.rx_data;
                  2'd1: word_d[15:8]  = bus.rx_data;
                  2'd2: word_d[23:16] = bus.rx_data;
                  default: begin
                     instr_we_d     = 1'b1;
                     instr_in_d     = {bus.rx_data, word_q};
                     addr_d         = ADDR_BASE + {14'd0, word_idx_q, 2'b00};
                     word_idx_d     = word_idx_q + 16'd1;
                     words_loaded_d = words_loaded_q + 16'd1;
                  end
               endcase
            end
         end
         default: ;
      endcase
      // Ready drops as soon as the last byte is taken so nothing trails the load.
      rx_ready_d  = (state_d == LEN_LO || state_d == LEN_HI || state_d == DATA) && !final_byte;
      core_hold_d = (state_d != DONE);
      load_done_d = (state_d == DONE);
      load_err_d  = (state_d == ERROR);
   end

   assign bus.rx_ready      = rx_ready_q;
   assign bus.instr_we      = instr_we_q;
   assign bus.instr_in      = instr_in_q;
   assign bus.instr_in_addr = addr_q;
   assign core_hold         = core_hold_q;
   assign load_done         = load_done_q;
   assign load_err          = load_err_q;
   assign words_loaded      = words_loaded_q;
endmodule
